composite_video_rx: RTL and testbench

COMPOSITE_VIDEO_RX -- requirements
Module: composite_video_rx

---
 rtl/composite_video_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_composite_video_rx.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/composite_video_rx.sv
// composite_video_rx: sync slicer, line/frame timing and luma extraction for
// a digitized composite video stream.
//
// Optional feature: define COMPOSITE_VIDEO_RX_FLYWHEEL_EN to let a locked
// receiver insert a synthetic line start when an expected hsync is missing.
//
// Ports:
//   clk          27 MHz system clock
//   reset        synchronous, active-high
//   adc_sample   8-bit digitized composite video
//   adc_valid    sample strobe; all state advances only on valid samples
//   hsync_pulse  one-cycle pulse on a qualified hsync (also on vsync)
//   vsync_pulse  one-cycle pulse on a qualified vsync
//   pixel_count  samples since line start, saturating at 2047
//   line_count   lines since vsync, saturating at 1023
//   pixel_data   luma, registered one cycle after the sample
//   pixel_valid  pixel_data is an active pixel
//   locked       horizontal lock achieved
module composite_video_rx #(
  parameter logic [7:0] SYNC_THRESH = 8'h10,
  parameter logic [7:0] BLACK_LEVEL = 8'h20,
  parameter logic [7:0] WHITE_LEVEL = 8'hA0,
  parameter int H_TOTAL     = 858,
  parameter int H_TOL       = 8,
  parameter int H_SYNC_MIN  = 40,
  parameter int H_SYNC_MAX  = 100,
  parameter int V_SYNC_MIN  = 400,
  parameter int H_ACT_START = 60,
  parameter int H_ACT_LEN   = 720,
  parameter int V_ACT_START = 30,
  parameter int V_ACT_LEN   = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  adc_sample,
  input  logic        adc_valid,
  output logic        hsync_pulse,
  output logic        vsync_pulse,
  output logic [10:0] pixel_count,
  output logic [9:0]  line_count,
  output logic [7:0]  pixel_data,
  output logic        pixel_valid,
  output logic        locked
);

`ifdef COMPOSITE_VIDEO_RX_FLYWHEEL_EN
  localparam bit FLYWHEEL = 1'b1;
`else
  localparam bit FLYWHEEL = 1'b0;
`endif

  // All length comparisons are done at 13 bits.
  localparam logic [12:0] C_HS_MIN  = 13'(H_SYNC_MIN);
  localparam logic [12:0] C_HS_MAX  = 13'(H_SYNC_MAX);
  localparam logic [12:0] C_VS_MIN  = 13'(V_SYNC_MIN);
  localparam logic [12:0] C_PER_MIN = 13'(H_TOTAL - H_TOL);
  localparam logic [12:0] C_PER_MAX = 13'(H_TOTAL + H_TOL);
  localparam logic [12:0] C_ACT_H0  = 13'(H_ACT_START);
  localparam logic [12:0] C_ACT_H1  = 13'(H_ACT_START + H_ACT_LEN);
  localparam logic [12:0] C_ACT_V0  = 13'(V_ACT_START);
  localparam logic [12:0] C_ACT_V1  = 13'(V_ACT_START + V_ACT_LEN);
  localparam logic [12:0] C_FLY_LEN = 13'(H_TOL);
  localparam logic [10:0] C_FLY_PIX = 11'(H_TOL);

  typedef enum logic {S_HIGH, S_LOW}    slice_t;
  typedef enum logic {L_SEARCH, L_LOCK} lock_t;

  slice_t      r_slice, w_slice_nxt;
  lock_t       r_lock,  w_lock_nxt;
  logic [12:0] r_run,   w_run_nxt;
  logic [12:0] r_len,   w_len_nxt;
  logic [10:0] r_pix,   w_pix_nxt;
  logic [9:0]  r_line,  w_line_nxt;
  logic [1:0]  r_good,  w_good_nxt;
  logic        r_miss,  w_miss_nxt;
  logic        r_hs, w_hs_nxt, r_vs, w_vs_nxt, r_pv, w_pv_nxt;
  logic [7:0]  r_pd,    w_pd_nxt;
  logic        w_miss_ev;

  logic        w_below, w_edge, w_is_h, w_is_v, w_good_per, w_tout, w_active;
  logic [12:0] w_len_p1, w_len_inc, w_run_inc;
  logic [10:0] w_pix_inc;
  logic [9:0]  w_line_inc;
  logic [7:0]  w_diff, w_luma;
  logic [8:0]  w_dbl;

  assign w_below  = adc_sample < SYNC_THRESH;
  assign w_edge   = (r_slice == S_LOW) && !w_below;
  // A run long enough for vsync wins over the hsync window.
  assign w_is_v   = w_edge && (r_run >= C_VS_MIN);
  assign w_is_h   = w_edge && !w_is_v && (r_run >= C_HS_MIN) && (r_run <= C_HS_MAX);

  // The period includes the trailing-edge sample itself.
  assign w_len_p1   = r_len + 13'd1;
  assign w_len_inc  = (&r_len)  ? r_len  : w_len_p1;
  assign w_run_inc  = (&r_run)  ? r_run  : r_run + 13'd1;
  assign w_pix_inc  = (&r_pix)  ? r_pix  : r_pix + 11'd1;
  assign w_line_inc = (&r_line) ? r_line : r_line + 10'd1;
  assign w_good_per = !(&r_len) && (w_len_p1 >= C_PER_MIN) && (w_len_p1 <= C_PER_MAX);

  // Timeout is not judged while a sync pulse is in progress: its trailing
  // edge decides (hsync priority, and a long vsync run never breaks lock).
  assign w_tout = (r_lock == L_LOCK) && (r_slice == S_HIGH) && (w_len_p1 == C_PER_MAX);

  // Active window uses the counters as they stand for this sample.
  assign w_active = (r_lock == L_LOCK) &&
                    ({2'b00, r_pix}  >= C_ACT_H0) && ({2'b00, r_pix}  < C_ACT_H1) &&
                    ({3'b000, r_line} >= C_ACT_V0) && ({3'b000, r_line} < C_ACT_V1);

  assign w_diff = adc_sample - BLACK_LEVEL;
  assign w_dbl  = {w_diff, 1'b0};
  assign w_luma = (adc_sample <= BLACK_LEVEL) ? 8'd0   :
                  (adc_sample >= WHITE_LEVEL) ? 8'd255 :
                  (w_dbl[8] ? 8'd255 : w_dbl[7:0]);

  always_comb begin
    w_slice_nxt = r_slice;
    w_run_nxt   = r_run;
    w_lock_nxt  = r_lock;
    w_good_nxt  = r_good;
    w_miss_nxt  = r_miss;
    w_len_nxt   = r_len;
    w_pix_nxt   = r_pix;
    w_line_nxt  = r_line;
    w_hs_nxt    = 1'b0;
    w_vs_nxt    = 1'b0;
    w_pv_nxt    = 1'b0;
    w_pd_nxt    = r_pd;
    w_miss_ev   = 1'b0;
    if (adc_valid) begin
      // Slicer
      if (r_slice == S_HIGH) begin
        if (w_below) begin
          w_slice_nxt = S_LOW;
          w_run_nxt   = 13'd1;
        end
      end else if (w_below) begin
        w_run_nxt = w_run_inc;
      end else begin
        w_slice_nxt = S_HIGH;
      end

      w_pd_nxt = w_luma;
      w_pv_nxt = w_active;

      // Line timing and lock
      if (w_is_v) begin
        w_hs_nxt   = 1'b1;
        w_vs_nxt   = 1'b1;
        w_line_nxt = '0;
        w_pix_nxt  = '0;
        w_len_nxt  = '0;
      end else if (w_is_h) begin
        w_hs_nxt   = 1'b1;
        w_pix_nxt  = '0;
        w_len_nxt  = '0;
        w_line_nxt = w_line_inc;
        if (r_lock == L_SEARCH) begin
          if (!w_good_per) begin
            w_good_nxt = '0;
          end else if (r_good == 2'd3) begin
            w_lock_nxt = L_LOCK;
            w_good_nxt = '0;
            w_miss_nxt = 1'b0;
          end else begin
            w_good_nxt = r_good + 2'd1;
          end
        end else if (w_good_per) begin
          w_miss_nxt = 1'b0;
        end else begin
          w_miss_ev = 1'b1;
        end
      end else begin
        w_pix_nxt = w_pix_inc;
        w_len_nxt = w_len_inc;
        if (w_tout) begin
          w_miss_ev = 1'b1;
          if (FLYWHEEL) begin
            w_line_nxt = w_line_inc;
            w_pix_nxt  = C_FLY_PIX;
            w_len_nxt  = C_FLY_LEN;
          end
        end
      end

      if (w_miss_ev) begin
        if (r_miss) begin
          w_lock_nxt = L_SEARCH;
          w_miss_nxt = 1'b0;
          w_good_nxt = '0;
        end else begin
          w_miss_nxt = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_slice <= S_HIGH;
      r_lock  <= L_SEARCH;
      r_run   <= '0;
      r_len   <= '0;
      r_pix   <= '0;
      r_line  <= '0;
      r_good  <= '0;
      r_miss  <= 1'b0;
      r_hs    <= 1'b0;
      r_vs    <= 1'b0;
      r_pv    <= 1'b0;
      r_pd    <= '0;
    end else begin
      r_slice <= w_slice_nxt;
      r_lock  <= w_lock_nxt;
      r_run   <= w_run_nxt;
      r_len   <= w_len_nxt;
      r_pix   <= w_pix_nxt;
      r_line  <= w_line_nxt;
      r_good  <= w_good_nxt;
      r_miss  <= w_miss_nxt;
      r_hs    <= w_hs_nxt;
      r_vs    <= w_vs_nxt;
      r_pv    <= w_pv_nxt;
      r_pd    <= w_pd_nxt;
    end
  end

  assign hsync_pulse = r_hs;
  assign vsync_pulse = r_vs;
  assign pixel_count = r_pix;
  assign line_count  = r_line;
  assign pixel_data  = r_pd;
  assign pixel_valid = r_pv;
  assign locked      = (r_lock == L_LOCK);

endmodule

// File: tb/tb_composite_video_rx.sv
module tb_composite_video_rx;
  localparam int HT   = 858;
  localparam int HTOL = 8;
  localparam int SYNC = 62;
  localparam int VAS  = 3;
  localparam int VLEN = 4;
`ifdef COMPOSITE_VIDEO_RX_FLYWHEEL_EN
  localparam bit FLY = 1'b1;
`else
  localparam bit FLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  adc_sample;
  logic        adc_valid;
  logic        hsync_pulse, vsync_pulse, pixel_valid, locked;
  logic [10:0] pixel_count;
  logic [9:0]  line_count;
  logic [7:0]  pixel_data;

  composite_video_rx #(.V_ACT_START(VAS), .V_ACT_LEN(VLEN)) dut (
    .clk(clk), .reset(reset), .adc_sample(adc_sample), .adc_valid(adc_valid),
    .hsync_pulse(hsync_pulse), .vsync_pulse(vsync_pulse),
    .pixel_count(pixel_count), .line_count(line_count),
    .pixel_data(pixel_data), .pixel_valid(pixel_valid), .locked(locked));

  always #5 clk = ~clk;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [10:0] pix;
    logic [9:0]  line;
    logic [7:0]  pd;
    logic        pv;
    logic        lk;
  } resp_t;

  resp_t exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: plain integers describing the stream so far.
  bit m_low, m_lock;
  int m_run, m_since, m_pix, m_line, m_good, m_miss;

  function automatic logic [7:0] luma(input int s);
    int v;
    if (s <= 32)  return 8'd0;
    if (s >= 160) return 8'd255;
    v = (s - 32) * 2;
    return 8'((v > 255) ? 255 : v);
  endfunction

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic model_reset();
    m_low = 0; m_lock = 0; m_run = 0; m_since = 0;
    m_pix = 0; m_line = 0; m_good = 0; m_miss = 0;
  endtask

  task automatic model_miss();
    m_miss++;
    if (m_miss == 2) begin m_lock = 0; m_miss = 0; m_good = 0; end
  endtask

  task automatic model_period(input bit good);
    if (!m_lock) begin
      if (good) begin
        m_good++;
        if (m_good == 4) begin m_lock = 1; m_good = 0; m_miss = 0; end
      end else m_good = 0;
    end else if (good) m_miss = 0;
    else model_miss();
  endtask

  task automatic model_step(input logic [7:0] s);
    resp_t e;
    bit below, is_edge;
    int per;
    e.pv = m_lock && m_pix >= 60 && m_pix < 780 && m_line >= VAS && m_line < VAS + VLEN;
    e.pd = luma(int'(s));
    e.hs = 0; e.vs = 0;
    below   = s < 8'h10;
    is_edge = m_low && !below;
    per     = m_since + 1;
    if (is_edge && m_run >= 400) begin
      e.hs = 1; e.vs = 1; m_line = 0; m_pix = 0; m_since = 0;
    end else if (is_edge && m_run >= 40 && m_run <= 100) begin
      e.hs = 1; m_pix = 0; m_since = 0; m_line = sat(m_line + 1, 1023);
      model_period(per >= HT - HTOL && per <= HT + HTOL);
    end else if (m_lock && !m_low && per == HT + HTOL) begin
      model_miss();
      if (FLY) begin m_line = sat(m_line + 1, 1023); m_pix = HTOL; m_since = HTOL; end
      else begin m_pix = sat(m_pix + 1, 2047); m_since = per; end
    end else begin
      m_pix = sat(m_pix + 1, 2047); m_since = sat(per, 8191);
    end
    if (!m_low && below) begin m_low = 1; m_run = 1; end
    else if (m_low && below) m_run = sat(m_run + 1, 8191);
    else if (is_edge) m_low = 0;
    e.pix = 11'(m_pix); e.line = 10'(m_line); e.lk = m_lock;
    exp_q.push_back(e);
  endtask

  // Monitor: one response per accepted sample; idle cycles must be quiet.
  initial begin
    resp_t a, e;
    forever begin
      @(posedge clk);
      if (!reset && adc_valid) begin
        #1;
        a = {hsync_pulse, vsync_pulse, pixel_count, line_count, pixel_data, pixel_valid, locked};
        if (exp_q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL resp: got %h required <none, queue empty>", a);
        end else begin
          e = exp_q.pop_front();
          check("resp{hs,vs,pix,line,pd,pv,lk}", 64'(a), 64'(e));
        end
      end else if (!reset) begin
        #1;
        check("idle{hs,vs,pv}", 64'({hsync_pulse, vsync_pulse, pixel_valid}), 64'(0));
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic put(input logic [7:0] s);
    if ($urandom_range(0, 4) == 0) begin
      adc_valid = 1'b0; adc_sample = 8'($urandom); @(negedge clk);
    end
    adc_sample = s; adc_valid = 1'b1; model_step(s); @(negedge clk);
  endtask

  // kind: 0 flat black, 1 random video, 2 flat with hsync dropped,
  //       3 random with directed luma values, 4 random with a 10-sample glitch
  task automatic send_line(input int kind);
    logic [7:0] lut [6];
    logic [7:0] v;
    lut = '{8'h10, 8'h20, 8'h60, 8'h9F, 8'hA0, 8'hFF};
    for (int i = 0; i < HT - SYNC; i++) begin
      if (kind == 0 || kind == 2) v = 8'h20;
      else v = 8'($urandom_range(16, 255));
      if (kind == 3 && i >= 100 && i < 106) v = lut[i - 100];
      if (kind == 4 && i >= 300 && i < 310) v = 8'h00;
      put(v);
    end
    for (int i = 0; i < SYNC; i++) put((kind == 2) ? 8'h20 : 8'h00);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".hs"},   64'(hsync_pulse), 64'(0));
    check({tag, ".vs"},   64'(vsync_pulse), 64'(0));
    check({tag, ".pv"},   64'(pixel_valid), 64'(0));
    check({tag, ".lk"},   64'(locked),      64'(0));
    check({tag, ".pd"},   64'(pixel_data),  64'(0));
    check({tag, ".pix"},  64'(pixel_count), 64'(0));
    check({tag, ".line"}, 64'(line_count),  64'(0));
  endtask

  initial begin
    reset = 1'b1; adc_valid = 1'b0; adc_sample = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    reset = 1'b0;

    // Ideal lines: lock after the 4th good hsync.
    for (int l = 0; l < 6; l++) send_line(0);
    check("locked_after_ideal", 64'(locked), 64'(1));

    // Vsync: six lines of low, then lines with active window and luma.
    for (int i = 0; i < HT - SYNC; i++) put(8'h20);
    for (int i = 0; i < 6 * HT; i++) put(8'h00);
    send_line(1); send_line(1); send_line(1);
    send_line(3); send_line(4);
    send_line(1); send_line(1); send_line(1); send_line(1);
    check("locked_after_vsync", 64'(locked), 64'(1));

    // One dropped hsync, recover, then two in a row.
    send_line(2);
    for (int l = 0; l < 3; l++) send_line(1);
    send_line(2); send_line(2);
    send_line(1); send_line(1);
    check("unlocked_after_two_drops", 64'(locked), 64'(0));

    // Relock, then reset in the middle of a sync pulse with adc_valid high.
    for (int l = 0; l < 5; l++) send_line(1);
    for (int i = 0; i < HT - SYNC; i++) put(8'h30);
    for (int i = 0; i < 30; i++) put(8'h00);
    reset = 1'b1; adc_valid = 1'b1; adc_sample = 8'h00;
    model_reset();
    @(negedge clk);
    check_zero_outputs("midsync_reset");
    reset = 1'b0;
    for (int l = 0; l < 4; l++) send_line(1);
    check("not_yet_relocked", 64'(locked), 64'(0));
    send_line(1);
    check("relocked", 64'(locked), 64'(1));

    adc_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
